multi_road_signal_controller: RTL and testbench

- N-approach intersection signal controller. Road 0 is the priority main road; roads 1..N_ROADS-1 are demand-actuated side roads.
- Next generation of the two-road highway/country controller. Adds a parametrised road count and parametrised phase durations.
- New behaviour: all-red clearance, round-robin service among side roads, and an emergency preempt that returns right-of-way to road 0.
- Sits between the vehicle sensor front-end and the lamp drivers.

---
 rtl/multi_road_signal_controller_pkg.sv | 21 ++
 rtl/multi_road_signal_controller_phase_timer.sv | 31 +++
 rtl/multi_road_signal_controller.sv | 172 +++++++++++++++++
 tb/tb_multi_road_signal_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_road_signal_controller_pkg.sv
// rtl/multi_road_signal_controller_pkg.sv - shared lamp codes, phase codes and duration helper
package multi_road_signal_controller_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    PH_MAIN_G = 3'd0,
    PH_MAIN_Y = 3'd1,
    PH_ALLRED = 3'd2,
    PH_SIDE_G = 3'd3,
    PH_SIDE_Y = 3'd4
  } phase_e;

  // Seconds to clock cycles.
  function automatic int dur_cycles(input int t_s, input int clk_hz);
    return t_s * clk_hz;
  endfunction

endpackage

// File: rtl/multi_road_signal_controller_phase_timer.sv
// rtl/multi_road_signal_controller_phase_timer.sv - phase timer with clear, saturation and expiry compare
module multi_road_signal_controller_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Expiry is the last cycle of a phase lasting dur_i cycles.
  assign expire_o = (cnt_q == (dur_i - ONE));

  // Count up from zero after each clear; hold at the expiry value so a
  // phase that is allowed to overrun keeps reporting expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (!expire_o) begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/multi_road_signal_controller.sv
// rtl/multi_road_signal_controller.sv - N-approach signal controller with round-robin side service and preempt
module multi_road_signal_controller
  import multi_road_signal_controller_pkg::*;
#(
  parameter int N_ROADS      = 4,
  parameter int CLK_HZ       = 50,
  parameter int T_MAIN_MIN_S = 120,
  parameter int T_SIDE_MAX_S = 30,
  parameter int T_YELLOW_S   = 5,
  parameter int T_ALLRED_S   = 1,
  parameter int CNT_W        = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ROADS-1:0]         sensor,
  input  logic                       emerg,
  output logic [3*N_ROADS-1:0]       lights,
  output logic [2:0]                 phase,
  output logic [$clog2(N_ROADS)-1:0] served
);

  localparam int RW = $clog2(N_ROADS);

  localparam logic [CNT_W-1:0] D_MAIN   = CNT_W'(dur_cycles(T_MAIN_MIN_S, CLK_HZ));
  localparam logic [CNT_W-1:0] D_SIDE   = CNT_W'(dur_cycles(T_SIDE_MAX_S, CLK_HZ));
  localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(dur_cycles(T_YELLOW_S, CLK_HZ));
  localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(dur_cycles(T_ALLRED_S, CLK_HZ));

  phase_e                 state_q, state_d;
  logic                   min_done_q, min_done_d;
  logic                   to_side_q, to_side_d;
  logic [RW-1:0]          rr_q, rr_d;
  logic [RW-1:0]          next_q, next_d;
  logic [RW-1:0]          served_q, served_d;
  logic [3*N_ROADS-1:0]   lights_q;
  logic [CNT_W-1:0]       dur;
  logic                   expire;
  logic                   clr;
  logic                   any_side;
  logic [RW-1:0]          pick;

  // First requesting side road after ptr, searching circularly over 1..N-1.
  function automatic logic [RW-1:0] pick_next(input logic [N_ROADS-1:0] req,
                                               input logic [RW-1:0]      ptr);
    logic [RW-1:0] res;
    logic          found;
    int            idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k < N_ROADS; k++) begin
      idx = ((int'(ptr) - 1 + k) % (N_ROADS - 1)) + 1;
      if (!found && req[idx]) begin
        res   = RW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Lamp pattern for a phase: at most one road is ever off RED.
  function automatic logic [3*N_ROADS-1:0] decode_lamps(input phase_e ph, input logic [RW-1:0] srv);
    logic [3*N_ROADS-1:0] l;
    for (int i = 0; i < N_ROADS; i++) l[3*i +: 3] = LAMP_RED;
    case (ph)
      PH_MAIN_G: l[2:0] = LAMP_GREEN;
      PH_MAIN_Y: l[2:0] = LAMP_YELLOW;
      PH_SIDE_G: l[3*int'(srv) +: 3] = LAMP_GREEN;
      PH_SIDE_Y: l[3*int'(srv) +: 3] = LAMP_YELLOW;
      default:   ;
    endcase
    return l;
  endfunction

  assign any_side = |sensor[N_ROADS-1:1];
  assign pick     = pick_next(sensor, rr_q);

  // Duration of the phase currently running.
  always_comb begin
    dur = D_MAIN;
    case (state_q)
      PH_MAIN_G:            dur = D_MAIN;
      PH_MAIN_Y, PH_SIDE_Y: dur = D_YELLOW;
      PH_ALLRED:            dur = D_ALLRED;
      PH_SIDE_G:            dur = D_SIDE;
      default:              dur = CNT_W'(1);
    endcase
  end

  multi_road_signal_controller_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .dur_i    (dur),
    .expire_o (expire)
  );

  // Next-state and bookkeeping decisions, taken only at phase boundaries.
  always_comb begin
    state_d  = state_q;
    to_side_d = to_side_q;
    rr_d     = rr_q;
    next_d   = next_q;
    served_d = served_q;
    case (state_q)
      PH_MAIN_G: begin
        if ((min_done_q || expire) && any_side && !emerg) begin
          state_d = PH_MAIN_Y;
          next_d  = pick;
        end
      end
      PH_MAIN_Y: begin
        if (expire) begin
          state_d   = PH_ALLRED;
          to_side_d = 1'b1;
        end
      end
      PH_ALLRED: begin
        if (expire) begin
          state_d  = to_side_q ? PH_SIDE_G : PH_MAIN_G;
          served_d = to_side_q ? next_q : '0;
        end
      end
      PH_SIDE_G: begin
        if (expire || !sensor[served_q] || emerg) begin
          state_d = PH_SIDE_Y;
          rr_d    = served_q;
        end
      end
      PH_SIDE_Y: begin
        if (expire) begin
          state_d   = PH_ALLRED;
          to_side_d = 1'b0;
        end
      end
      default: begin
        state_d   = PH_MAIN_G;
        to_side_d = 1'b0;
        served_d  = '0;
      end
    endcase
    clr        = (state_d != state_q);
    min_done_d = clr ? 1'b0 : (min_done_q || (state_q == PH_MAIN_G && expire));
  end

  // State register with lamps registered alongside so they switch with the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PH_MAIN_G;
      min_done_q <= 1'b0;
      to_side_q  <= 1'b0;
      rr_q       <= RW'(N_ROADS - 1);
      next_q     <= '0;
      served_q   <= '0;
      lights_q   <= decode_lamps(PH_MAIN_G, '0);
    end else begin
      state_q    <= state_d;
      min_done_q <= min_done_d;
      to_side_q  <= to_side_d;
      rr_q       <= rr_d;
      next_q     <= next_d;
      served_q   <= served_d;
      lights_q   <= decode_lamps(state_d, served_d);
    end
  end

  assign lights = lights_q;
  assign phase  = state_q;
  assign served = served_q;

endmodule

// File: tb/tb_multi_road_signal_controller.sv
// tb/tb_multi_road_signal_controller.sv - self-checking bench with behavioural reference model
module tb_multi_road_signal_controller;

  localparam int N  = 4;
  localparam int DM = 4;
  localparam int DS = 3;
  localparam int DY = 2;
  localparam int DA = 1;
  localparam logic [11:0] RST_LIGHTS = 12'b100_100_100_001;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sensor;
  logic        emerg;
  logic [11:0] lights;
  logic [2:0]  phase;
  logic [1:0]  served;

  always #5 clk = ~clk;

  multi_road_signal_controller #(
    .N_ROADS(4), .CLK_HZ(1), .T_MAIN_MIN_S(4), .T_SIDE_MAX_S(3),
    .T_YELLOW_S(2), .T_ALLRED_S(1), .CNT_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sensor (sensor),
    .emerg  (emerg),
    .lights (lights),
    .phase  (phase),
    .served (served)
  );

  int checks = 0;
  int errors = 0;

  int m_ph, m_el, m_rr, m_next, m_srv;
  bit m_to_side;
  logic [11:0] prev_lights;
  bit prev_valid;

  function automatic logic [11:0] exp_lights(input int ph, input int srv);
    logic [11:0] l;
    for (int i = 0; i < N; i++) l[3*i +: 3] = 3'b100;
    case (ph)
      0: l[2:0] = 3'b001;
      1: l[2:0] = 3'b010;
      3: l[3*srv +: 3] = 3'b001;
      4: l[3*srv +: 3] = 3'b010;
      default: ;
    endcase
    return l;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_rr = N - 1; m_next = 0; m_srv = 0; m_to_side = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic e);
    int nph;
    bit found;
    int cand;
    nph = m_ph;
    case (m_ph)
      0: if (m_el >= DM - 1 && s[3:1] != 3'b000 && !e) begin
        nph = 1;
        found = 0;
        for (int k = 1; k < N; k++) begin
          cand = ((m_rr - 1 + k) % (N - 1)) + 1;
          if (!found && s[cand]) begin m_next = cand; found = 1; end
        end
      end
      1: if (m_el == DY - 1) begin nph = 2; m_to_side = 1; end
      2: if (m_el == DA - 1) begin
        nph = m_to_side ? 3 : 0;
        m_srv = m_to_side ? m_next : 0;
      end
      3: if (m_el == DS - 1 || !s[m_srv] || e) begin nph = 4; m_rr = m_srv; end
      4: if (m_el == DY - 1) begin nph = 2; m_to_side = 0; end
      default: nph = 0;
    endcase
    if (nph != m_ph) begin m_ph = nph; m_el = 0; end
    else m_el++;
  endtask

  task automatic compare_now();
    int nonred;
    chk("lights", int'(lights), int'(exp_lights(m_ph, m_srv)));
    chk("phase", int'(phase), m_ph);
    if (m_ph == 0 || m_ph == 1) chk("served_main", int'(served), 0);
    else if (m_ph == 3 || m_ph == 4 || (m_ph == 2 && !m_to_side)) chk("served_side", int'(served), m_srv);
    nonred = 0;
    for (int i = 0; i < N; i++) begin
      if (lights[3*i +: 3] != 3'b100) nonred++;
      if (prev_valid && prev_lights[3*i +: 3] == 3'b001) chk("no_green_to_red", int'(lights[3*i +: 3] == 3'b100), 0);
    end
    chk("one_nonred", int'(nonred <= 1), 1);
    chk("phase_legal", int'(phase <= 3'd4), 1);
    prev_lights = lights;
    prev_valid = 1;
  endtask

  task automatic do_cycle(input logic [3:0] s, input logic e);
    compare_now();
    sensor = s;
    emerg  = e;
    model_step(s, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_lights", int'(lights), int'(RST_LIGHTS));
    chk("rst_phase", int'(phase), 0);
    chk("rst_served", int'(served), 0);
    model_reset();
    prev_valid = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ph(input int target, input logic [3:0] s, input logic e, input string name);
    int n;
    n = 0;
    while (m_ph != target && n < 60) begin
      do_cycle(s, e);
      n++;
    end
    chk(name, int'(m_ph == target), 1);
  endtask

  int lit_cap[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 2, 0};
  int lit_gap[4]  = '{4, 4, 2, 0};
  int lit_rr[4]   = '{1, 2, 3, 1};

  initial begin
    int order[$];
    int mg_len;
    int prev_ph;
    int n;
    logic [3:0] rs;
    logic re;

    rst = 1'b1; sensor = 4'b0000; emerg = 1'b0;
    prev_valid = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Max-green cap with road 2 requesting.
    for (int k = 0; k < 14; k++) begin
      chk("cap_phase", int'(phase), lit_cap[k]);
      chk("cap_model", m_ph, lit_cap[k]);
      if (lit_cap[k] == 3) chk("cap_served", int'(served), 2);
      do_cycle(4'b0100, 1'b0);
    end

    // Early gap-out on road 1.
    do_reset();
    wait_ph(3, 4'b0010, 1'b0, "gap_reach_side");
    for (int j = 0; j < 4; j++) begin
      do_cycle(4'b0000, 1'b0);
      chk("gap_phase", int'(phase), lit_gap[j]);
    end

    // Emergency preempt.
    do_reset();
    wait_ph(3, 4'b0010, 1'b0, "emerg_reach_side");
    do_cycle(4'b0010, 1'b0);
    do_cycle(4'b0010, 1'b1);
    chk("emerg_exit", int'(phase), 4);
    for (int j = 0; j < 12; j++) do_cycle(4'b1110, 1'b1);
    chk("emerg_hold", int'(phase), 0);
    do_cycle(4'b1110, 1'b0);
    chk("emerg_release", int'(phase), 1);

    // Round-robin order over roads 1..3.
    do_reset();
    mg_len = 0; prev_ph = 0; n = 0;
    while (order.size() < 4 && n < 200) begin
      do_cycle(4'b1110, 1'b0);
      n++;
      if (phase == 3'd0) mg_len++;
      if (phase == 3'd3 && prev_ph != 3) begin
        if (order.size() > 0) chk("rr_main_len", int'(mg_len >= 4), 1);
        order.push_back(int'(served));
        mg_len = 0;
      end
      prev_ph = int'(phase);
    end
    chk("rr_count", order.size(), 4);
    for (int j = 0; j < 4 && j < order.size(); j++) chk("rr_order", order[j], lit_rr[j]);

    // Reset mid MAIN_Y restarts the search at road 1.
    wait_ph(1, 4'b1110, 1'b0, "rstmy_reach_my");
    do_cycle(4'b1110, 1'b0);
    do_reset();
    wait_ph(3, 4'b1110, 1'b0, "rstmy_reach_side");
    chk("rstmy_served", int'(served), 1);

    // Randomised traffic with preempt episodes and occasional resets.
    rs = 4'b0000; re = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 2) do_reset();
      if ($urandom_range(0, 99) < 4) re = ~re;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) rs[b] = ~rs[b];
      do_cycle(rs, re);
    end
    compare_now();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
